// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds state encodings, header tag default and header byte helper.
package uart_sched_pkg;

    localparam int ID_W = 4;
    localparam logic [3:0] HDR_TAG_DEF = 4'hA;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_HDR    = 3'd1;
    localparam state_t ST_WAIT_H = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_WAIT_D = 3'd4;

    function automatic logic [7:0] hdr_byte(
        input logic [3:0]      tag,
        input logic [ID_W-1:0] id
    );
        return {tag, id};
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: first set request at or above ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant
);

    logic [W:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (W+1)'(i);
            if (idx >= (W+1)'(N))
                idx = idx - (W+1)'(N);
            if (!grant_valid && req[idx[W-1:0]]) begin
                grant_valid = 1'b1;
                grant       = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler framing requester bytes as header+data pairs,
// paced GAP cycles apart for a UART tx FIFO that has no full flag.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int         NUM_REQ = 4,
    parameter int         GAP     = 100,
    parameter logic [3:0] HDR_TAG = HDR_TAG_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [7:0]           tx_byte,
    output logic                 tx_ready,
    output logic                 busy
);

    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (GAP > 2) ? $clog2(GAP) : 1;
    // WAIT_H spans GAP-1 cycles; WAIT_D spans GAP-2 so the IDLE grant
    // cycle fits inside the data-to-header gap.
    localparam int LOAD_H = GAP - 2;
    localparam int LOAD_D = (GAP > 2) ? GAP - 3 : 0;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   id;
    logic [7:0]      data;
    logic            gnt_valid;
    logic [PW-1:0]   gnt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant_valid (gnt_valid),
        .grant       (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rr_ptr   <= '0;
            id       <= '0;
            data     <= '0;
            req_ack  <= '0;
            tx_byte  <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            req_ack  <= '0;
            tx_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && gnt_valid) begin
                        id      <= gnt;
                        data    <= req_data[{gnt, 3'b000} +: 8];
                        req_ack <= NUM_REQ'(1) << gnt;
                        rr_ptr  <= (gnt == PW'(NUM_REQ - 1))
                                   ? '0 : gnt + 1'b1;
                        state   <= ST_HDR;
                        busy    <= 1'b1;
                    end
                end
                ST_HDR: begin
                    tx_byte  <= hdr_byte(HDR_TAG, ID_W'(id));
                    tx_ready <= 1'b1;
                    cnt      <= CNT_W'(LOAD_H);
                    state    <= ST_WAIT_H;
                end
                ST_WAIT_H: begin
                    if (cnt == '0)
                        state <= ST_DATA;
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_DATA: begin
                    tx_byte  <= data;
                    tx_ready <= 1'b1;
                    if (GAP > 2) begin
                        cnt   <= CNT_W'(LOAD_D);
                        state <= ST_WAIT_D;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_WAIT_D: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table-driven packets plus
// hand-written enable, withdrawal and reset sequences.
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ack;
    logic [7:0]  tx_byte;
    logic        tx_ready;
    logic        busy;

    uart_tx_scheduler #(.NUM_REQ(N), .GAP(GAP), .HDR_TAG(4'hA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .tx_byte   (tx_byte),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (req_ack == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_ready && n < limit);
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  after;
        logic [31:0] data;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_hdr;
        logic [7:0]  exp_dat;
        bit          chained;
        bit          idle_chk;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int dcyc;
        int a3;
        int acks3;
        int strobes;

        vecs[0] = '{4'b0100, 4'b0000, 32'h135C1110, 4'b0100, 8'hA2, 8'h5C, 0, 1};
        vecs[1] = '{4'b0011, 4'b0010, 32'h135C1110, 4'b0001, 8'hA0, 8'h10, 0, 1};
        vecs[2] = '{4'b0010, 4'b0000, 32'h135C1110, 4'b0010, 8'hA1, 8'h11, 0, 1};
        vecs[3] = '{4'b1111, 4'b1111, 32'h13121110, 4'b0100, 8'hA2, 8'h12, 0, 0};
        vecs[4] = '{4'b1111, 4'b1111, 32'h13121110, 4'b1000, 8'hA3, 8'h13, 1, 0};
        vecs[5] = '{4'b1111, 4'b1111, 32'h13121110, 4'b0001, 8'hA0, 8'h10, 1, 0};
        vecs[6] = '{4'b1111, 4'b1111, 32'h13121110, 4'b0010, 8'hA1, 8'h11, 1, 0};
        vecs[7] = '{4'b1111, 4'b0000, 32'h13121110, 4'b0100, 8'hA2, 8'h12, 1, 1};
        dcyc = 0;

        repeat (3) @(negedge clk);
        chk("reset_ack", req_ack, 0);
        chk("reset_byte", tx_byte, 0);
        chk("reset_ready", tx_ready, 0);
        chk("reset_busy", busy, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            req_valid = vecs[i].mask;
            req_data  = vecs[i].data;
            wait_ack(n);
            if (!vecs[i].chained) chk("ack_latency", n, 1);
            chk("ack", req_ack, vecs[i].exp_ack);
            chk("no_strobe_on_ack", tx_ready, 0);
            req_valid = vecs[i].after;
            @(negedge clk);
            chk("hdr_strobe", tx_ready, 1);
            chk("hdr", tx_byte, vecs[i].exp_hdr);
            chk("ack_one_cycle", req_ack, 0);
            if (vecs[i].chained) chk("gap_d2h", cyc - dcyc, GAP);
            wait_strobe(3 * GAP, n);
            chk("gap_h2d", n, GAP);
            chk("data", tx_byte, vecs[i].exp_dat);
            dcyc = cyc;
            if (vecs[i].idle_chk) begin
                repeat (GAP - 3) @(negedge clk);
                chk("busy_wait_d", busy, 1);
                @(negedge clk);
                chk("busy_idle", busy, 0);
                chk("byte_hold", tx_byte, vecs[i].exp_dat);
                chk("ready_low", tx_ready, 0);
            end
        end

        // Enable dropped during WAIT_H of requester 1's packet.
        req_valid = 4'b0010;
        wait_ack(n);
        chk("en_ack1", req_ack, 4'b0010);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("en_hdr1", tx_byte, 8'hA1);
        enable    = 1'b0;
        req_valid = 4'b1000;
        wait_strobe(3 * GAP, n);
        chk("en_gap", n, GAP);
        chk("en_data1", tx_byte, 8'h11);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (req_ack != '0) n++;
        end
        chk("en_no_ack", n, 0);
        chk("en_idle", busy, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("en_resume_ack", req_ack, 4'b1000);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("en_hdr3", tx_byte, 8'hA3);
        wait_strobe(3 * GAP, n);
        chk("en_data3", tx_byte, 8'h13);
        repeat (GAP) @(negedge clk);

        // Request 3 pulses for one cycle while a packet is in flight.
        req_valid = 4'b0001;
        wait_ack(n);
        chk("wd_ack0", req_ack, 4'b0001);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("wd_hdr0", tx_byte, 8'hA0);
        @(negedge clk);
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = 4'b0000;
        a3 = 0;
        acks3 = 0;
        strobes = 0;
        repeat (3 * GAP + 10) begin
            @(negedge clk);
            if (req_ack[3]) acks3++;
            if (tx_ready) strobes++;
            if (tx_ready && tx_byte == 8'hA3) a3++;
        end
        chk("wd_no_ack3", acks3, 0);
        chk("wd_no_hdr3", a3, 0);
        chk("wd_one_data", strobes, 1);
        chk("wd_data0", tx_byte, 8'h10);

        // Reset during WAIT_H of requester 2's packet.
        req_valid = 4'b0100;
        wait_ack(n);
        chk("rst_ack2", req_ack, 4'b0100);
        req_valid = 4'b0101;
        @(negedge clk);
        chk("rst_hdr2", tx_byte, 8'hA2);
        @(negedge clk);
        chk("rst_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_ack", req_ack, 0);
        chk("rst_async_byte", tx_byte, 0);
        chk("rst_async_ready", tx_ready, 0);
        chk("rst_async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(n);
        chk("rst_ack0", req_ack, 4'b0001);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("rst_hdr0", tx_byte, 8'hA0);
        wait_strobe(3 * GAP, n);
        chk("rst_gap", n, GAP);
        chk("rst_data0", tx_byte, 8'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
